ram36_port_arbiter: RTL and testbench
=====================================

Name: ram36_port_arbiter

Overview:
Round-robin arbiter that shares one single-port 512x36 block RAM between two requesters. Each requester sees a simple 32-bit read/write command interface with valid/ready. The arbiter issues at most one RAM access per cycle and tracks the fixed RAM read latency. It routes each read result back to the requester that issued it. The block sits between user logic (e.g. switch/button-driven readout, a loader) and the RAM primitive in the 36-bit RAM feature designs.

Parameters:
ADDR_W, 9, RAM address width (512 words)
RD_LAT, 2, cycles from the cycle ram_en is high to valid ram_rdata; legal 1..4

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle
req0_we  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  word address
req0_wdata  in  32  write payload
rsp0_valid  out  1  read data valid for requester 0 (one-cycle pulse)
rsp0_rdata  out  32  read data
rsp0_perr  out  1  parity error on this response (0 without RAM_PARITY_EN)
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata, rsp1_perr  same as requester 0
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  36  RAM write data
ram_rdata  in  36  RAM read data
perr_count  out  8  saturating parity error count (0 without RAM_PARITY_EN)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. In the reset cycle, all tag pipeline entries are cleared and last_grant is set to 1, so requester 0 wins first. perr_count is set to 0.
- While rst is high: req*_ready=0, ram_en=0, rsp*_valid=0. Reset mid-operation drops in-flight reads; no responses appear for them afterward.
- Arbitration is combinational from valid signals and last_grant:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - Neither valid: no grant; last_grant holds.
- ready is asserted only on the granted requester, so at most one ready per cycle. A command is accepted when valid && ready.
- last_grant updates to the granted requester at the accepting edge.
- Fairness: under continuous contention, grants alternate 0,1,0,1. A waiting requester waits at most 1 cycle.
- RAM side, combinational in the accept cycle: ram_en=1, ram_we=req_we, ram_addr=req_addr, ram_wdata={4'b0, wdata}. Parity bits are defined under RAM_PARITY_EN.
- Tag pipeline: RD_LAT stages of {valid, id}. Stage 0 loads {accepted && !we, granted id}; the stages shift every cycle.
- Response:
  - When the last stage is valid, rspN_valid=1 for the tagged id only, for exactly one cycle.
  - rspN_rdata = ram_rdata[31:0], combinational.
  - Exact read latency: response visible RD_LAT cycles after the accept cycle.
- Writes produce no response.
- Back-to-back reads are allowed every cycle; responses return in issue order, one per cycle.
- Ordering: a read accepted after a write to the same address returns the written data.
- rsp*_rdata is 0 when the corresponding rsp*_valid is 0.

Optional Feature:
- RAM_PARITY_EN defined: ram_wdata[32+k] = even parity (XOR) of byte k of wdata, k=0..3. On each response, parity is recomputed over ram_rdata[31:0] and compared with ram_rdata[35:32]. Any mismatch sets rspN_perr=1 in the response cycle and increments perr_count, saturating at 255.
- Not defined: ram_wdata[35:32]=0, ram_rdata[35:32] ignored, rsp*_perr=0, perr_count=0.

Test Plan:
- Reset, then requester 0 writes 32'hAAAAAAAA to addr 5 and later reads addr 5 → rsp0_valid pulses exactly 2 cycles after read accept with rsp0_rdata=32'hAAAAAAAA; rsp1_valid stays 0.
- Both requesters hold read valid for 8 cycles (addrs 0..7 with 32'h00000001, 32'h55555555, ...) → grants alternate 0,1,0,1…, starting with 0. Each rsp returns to the issuing requester with the correct word. Exactly one ram_en per cycle.
- Requester 1 streams reads addr 0..510 back-to-back, requester 0 idle → req1_ready always 1; 511 consecutive rsp1_valid pulses in address order.
- rst asserted 1 cycle after two reads are accepted → no rsp*_valid in the following RD_LAT cycles; first post-reset grant goes to requester 0.
- RAM_PARITY_EN: write 32'hF0F0F0F0 and check ram_wdata[35:32]=4'b0000. Force ram_rdata[32] flipped on the read back → rsp0_perr=1 and perr_count=1. Then force 300 errors → perr_count=255.
- Write then read same address in consecutive cycles from different requesters → read returns new data.

Source files
------------

// File: rtl/ram36_port_arbiter.sv
// ram36_port_arbiter
//   Round-robin arbiter that lets two requesters share one single-port
//   512x36 block RAM. At most one RAM access is issued per cycle. A tag
//   pipeline RD_LAT deep remembers which requester issued each read, so that
//   every read result is steered back to that requester exactly RD_LAT
//   cycles after the command was accepted.
//
// Build option:
//   RAM_PARITY_EN  when defined, ram_wdata[35:32] carries even parity of the
//                  four write-data bytes, every read response is checked
//                  against it, rspN_perr flags a mismatch and perr_count
//                  counts mismatches (saturating at 255). When undefined,
//                  the parity bits are written as 0, ram_rdata[35:32] is
//                  ignored, rspN_perr is 0 and perr_count is 0.
//
// Ports:
//   clk, rst                    clock; synchronous active-high reset
//   reqN_valid/ready            command handshake (N = 0, 1)
//   reqN_we/addr/wdata          1 = write, word address, write payload
//   rspN_valid                  one-cycle read-data pulse for requester N
//   rspN_rdata                  read data (0 when rspN_valid is 0)
//   rspN_perr                   parity error on this response
//   ram_en/we/addr/wdata        RAM primitive command side
//   ram_rdata                   RAM read data, valid RD_LAT cycles after ram_en
//   perr_count                  saturating parity error count
module ram36_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 2   // legal 1..4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [31:0]       req0_wdata,
    output logic              rsp0_valid,
    output logic [31:0]       rsp0_rdata,
    output logic              rsp0_perr,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [31:0]       req1_wdata,
    output logic              rsp1_valid,
    output logic [31:0]       rsp1_rdata,
    output logic              rsp1_perr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [35:0]       ram_wdata,
    input  logic [35:0]       ram_rdata,
    output logic [7:0]        perr_count
);

`ifdef RAM_PARITY_EN
    // Even parity of each byte: bit k is the XOR of byte k.
    function automatic logic [3:0] byte_parity(input logic [31:0] d);
        logic [3:0] p;
        p = '0;
        for (int k = 0; k < 4; k++) begin
            p[k] = ^d[8*k +: 8];
        end
        return p;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction
`endif

    logic              last_grant;
    logic              gnt_vld;
    logic              gnt_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        wpar;
    logic [RD_LAT-1:0] vld_p;
    logic [RD_LAT-1:0] id_p;
    logic              rsp_vld;
    logic              rsp_id;

    // Grant: a lone requester wins; under contention the one that did not
    // win last time wins. Nothing is granted while rst is high.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = ~last_grant;
            end else if (req0_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end else if (req1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign req0_ready = gnt_vld && !gnt_id;
    assign req1_ready = gnt_vld &&  gnt_id;

    assign sel_we    = gnt_id ? req1_we    : req0_we;
    assign sel_addr  = gnt_id ? req1_addr  : req0_addr;
    assign sel_wdata = gnt_id ? req1_wdata : req0_wdata;

    assign ram_en    = gnt_vld;
    assign ram_we    = gnt_vld && sel_we;
    assign ram_addr  = sel_addr;
    assign ram_wdata = {wpar, sel_wdata};

    // Reset leaves last_grant at 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (gnt_vld) begin
            last_grant <= gnt_id;
        end
    end

    // ---- accept cycle -> tag stage 0 .. stage RD_LAT-1 -> response cycle ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            id_p  <= '0;
        end else begin
            vld_p[0] <= gnt_vld && !sel_we;
            id_p[0]  <= gnt_id;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                id_p[i]  <= id_p[i-1];
            end
        end
    end

    // Response is gated by rst so a tag still in flight during the reset
    // cycle itself never surfaces.
    assign rsp_vld = !rst && vld_p[RD_LAT-1];
    assign rsp_id  = id_p[RD_LAT-1];

    assign rsp0_valid = rsp_vld && !rsp_id;
    assign rsp1_valid = rsp_vld &&  rsp_id;
    assign rsp0_rdata = rsp0_valid ? ram_rdata[31:0] : 32'd0;
    assign rsp1_rdata = rsp1_valid ? ram_rdata[31:0] : 32'd0;

`ifdef RAM_PARITY_EN
    logic       perr_hit;
    logic [7:0] perr_cnt_q;

    assign wpar     = byte_parity(sel_wdata);
    assign perr_hit = rsp_vld && (byte_parity(ram_rdata[31:0]) != ram_rdata[35:32]);

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_cnt_q <= 8'd0;
        end else if (perr_hit) begin
            perr_cnt_q <= sat_inc(perr_cnt_q);
        end
    end

    assign perr_count = perr_cnt_q;
    assign rsp0_perr  = perr_hit && !rsp_id;
    assign rsp1_perr  = perr_hit &&  rsp_id;
`else
    // Stored parity bits are not examined in this build.
    logic unused_par;
    assign unused_par = ^ram_rdata[35:32];
    assign wpar       = 4'd0;
    assign perr_count = 8'd0;
    assign rsp0_perr  = 1'b0;
    assign rsp1_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_ram36_port_arbiter.sv
// Testbench for ram36_port_arbiter: a 512x36 RAM model with a two-cycle read
// path sits behind the DUT; a queue-based reference model predicts grants,
// RAM commands and every response cycle.
module tb_ram36_port_arbiter;
    localparam int ADDR_W = 9;
    localparam int RD_LAT = 2;
`ifdef RAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              req0_valid, req0_ready, req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [31:0]       req0_wdata;
    logic              rsp0_valid;
    logic [31:0]       rsp0_rdata;
    logic              rsp0_perr;
    logic              req1_valid, req1_ready, req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [31:0]       req1_wdata;
    logic              rsp1_valid;
    logic [31:0]       rsp1_rdata;
    logic              rsp1_perr;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [35:0]       ram_wdata;
    logic [35:0]       ram_rdata;
    logic [7:0]        perr_count;

    ram36_port_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_perr(rsp0_perr),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_perr(rsp1_perr),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .perr_count(perr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM primitive model: registered read, two cycles from ram_en to data.
    // flip corrupts stored parity bit 32 on the read being issued.
    logic              flip;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [35:0]       init_data;
    logic [35:0]       mem [512];
    logic [35:0]       rd_p1 = '0;
    logic [35:0]       rd_p2 = '0;

    always @(posedge clk) begin
        if (init_we) mem[init_addr] <= init_data;
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) rd_p1 <= mem[ram_addr] ^ {3'b000, flip, 32'd0};
        rd_p2 <= rd_p1;
    end
    assign ram_rdata = rd_p2;

    // Reference model state
    typedef struct {
        int          due;
        bit          id;
        logic [31:0] data;
        bit          perr;
    } rsp_t;

    rsp_t        rq[$];
    logic [31:0] shadow [512];
    int          m_last, m_cnt, cyc, last_eg, rsp1_pulses;
    int          errors, checks;
    logic [1:0]  g_obs;
    logic [3:0]  obs_wpar;
    int          i0, i1;
    bit          pv [2];
    bit          pwe [2];
    logic [8:0]  pa [2];
    logic [31:0] pd [2];
    logic [31:0] d;
    logic [31:0] pat [8] = '{32'h00000001, 32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF,
                             32'h00000000, 32'h80000000, 32'h12345678, 32'hDEADBEEF};

    function automatic logic [3:0] bpar(input logic [31:0] x);
        logic [3:0] p;
        p = '0;
        for (int k = 0; k < 4; k++) p[k] = ^x[8*k +: 8];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    endtask

    task automatic drive0(input logic we, input int a, input logic [31:0] wd);
        req0_valid = 1'b1; req0_we = we; req0_addr = 9'(a); req0_wdata = wd;
    endtask

    task automatic drive1(input logic we, input int a, input logic [31:0] wd);
        req1_valid = 1'b1; req1_we = we; req1_addr = 9'(a); req1_wdata = wd;
    endtask

    // One clock cycle: settle, compare every DUT output with the model,
    // advance the model, then move to the next falling edge.
    task automatic tick();
        int          eg;
        bit          have;
        rsp_t        r;
        rsp_t        n;
        logic        we_e;
        logic [8:0]  a_e;
        logic [31:0] d_e;
        #1;
        eg = -1;
        if (!rst) begin
            if (req0_valid && req1_valid) eg = 1 - m_last;
            else if (req0_valid)          eg = 0;
            else if (req1_valid)          eg = 1;
        end
        have = 1'b0;
        r.due = 0; r.id = 1'b0; r.data = '0; r.perr = 1'b0;
        if (!rst && rq.size() > 0) begin
            if (rq[0].due == cyc) begin
                have = 1'b1;
                r    = rq[0];
            end
        end
        we_e = (eg == 1) ? req1_we    : req0_we;
        a_e  = (eg == 1) ? req1_addr  : req0_addr;
        d_e  = (eg == 1) ? req1_wdata : req0_wdata;

        chk("ready0", 64'(req0_ready), 64'(eg == 0));
        chk("ready1", 64'(req1_ready), 64'(eg == 1));
        chk("ram_en", 64'(ram_en), 64'(eg >= 0));
        if (eg >= 0) begin
            chk("ram_we", 64'(ram_we), 64'(we_e));
            chk("ram_addr", 64'(ram_addr), 64'(a_e));
            if (we_e) chk("ram_wdata", 64'(ram_wdata), 64'({PAR ? bpar(d_e) : 4'd0, d_e}));
        end
        chk("rsp0_valid", 64'(rsp0_valid), 64'(have && !r.id));
        chk("rsp1_valid", 64'(rsp1_valid), 64'(have && r.id));
        chk("rsp0_rdata", 64'(rsp0_rdata), 64'((have && !r.id) ? r.data : 32'd0));
        chk("rsp1_rdata", 64'(rsp1_rdata), 64'((have && r.id) ? r.data : 32'd0));
        chk("rsp0_perr", 64'(rsp0_perr), 64'(have && !r.id && r.perr));
        chk("rsp1_perr", 64'(rsp1_perr), 64'(have && r.id && r.perr));
        if (!rst) chk("perr_count", 64'(perr_count), 64'(m_cnt));

        g_obs    = {req1_ready, req0_ready};
        obs_wpar = ram_wdata[35:32];
        if (rsp1_valid) rsp1_pulses++;

        if (rst) begin
            rq.delete();
            m_last = 1;
            m_cnt  = 0;
        end else begin
            if (have) begin
                if (r.perr && m_cnt < 255) m_cnt++;
                void'(rq.pop_front());
            end
            if (eg >= 0) begin
                if (we_e) begin
                    shadow[a_e] = d_e;
                end else begin
                    n.due  = cyc + RD_LAT;
                    n.id   = (eg == 1);
                    n.data = shadow[a_e];
                    n.perr = PAR && flip;
                    rq.push_back(n);
                end
                m_last = eg;
            end
        end
        last_eg = eg;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; m_last = 1; m_cnt = 0;
        rsp1_pulses = 0; last_eg = -1;
        rst = 1'b1; flip = 1'b0; init_we = 1'b0; init_addr = '0; init_data = '0;
        idle();
        @(negedge clk);

        // Preload RAM (DUT held in reset)
        for (int i = 0; i < 512; i++) begin
            d = $urandom;
            init_we   = 1'b1;
            init_addr = 9'(i);
            init_data = {PAR ? bpar(d) : 4'($urandom_range(0, 15)), d};
            shadow[i] = d;
            @(negedge clk);
        end
        init_we = 1'b0;

        // Reset state, with both requesters asserting valid
        drive0(1'b0, 1, 0); drive1(1'b0, 2, 0);
        tick(); tick();
        idle(); rst = 1'b0;

        // Write then read addr 5 from requester 0
        drive0(1'b1, 5, 32'hAAAAAAAA); tick();
        idle(); tick();
        drive0(1'b0, 5, 0); tick();
        idle(); tick(); tick(); tick();

        // Contention: fill addrs 0..7, reset, then both read continuously
        for (int i = 0; i < 8; i++) begin drive0(1'b1, i, pat[i]); tick(); end
        idle(); rst = 1'b1; tick(); rst = 1'b0;
        i0 = 0; i1 = 0;
        for (int c = 0; c < 8; c++) begin
            drive0(1'b0, 2*i0, 0); drive1(1'b0, 2*i1 + 1, 0);
            tick();
            chk("alt_grant", 64'(g_obs), (c % 2 == 0) ? 64'd1 : 64'd2);
            if (last_eg == 0) i0++;
            else if (last_eg == 1) i1++;
        end
        idle(); tick(); tick(); tick();

        // Requester 1 streams reads 0..510
        rsp1_pulses = 0;
        for (int a = 0; a < 511; a++) begin drive1(1'b0, a, 0); tick(); end
        idle(); tick(); tick(); tick();
        chk("stream_cnt", 64'(rsp1_pulses), 64'd511);

        // Write from requester 0 immediately followed by read from requester 1
        drive0(1'b1, 33, 32'hCAFEF00D); tick();
        idle(); drive1(1'b0, 33, 0); tick();
        idle(); tick(); tick(); tick();

        // Parity bits on write, corrupted read-back, saturation
        drive0(1'b1, 20, 32'hF0F0F0F0); tick();
        chk("wpar_f0", 64'(obs_wpar), 64'd0);
        idle(); drive0(1'b0, 20, 0); flip = 1'b1; tick();
        flip = 1'b0; idle(); tick(); tick(); tick();
        chk("perr_one", 64'(perr_count), PAR ? 64'd1 : 64'd0);
        flip = 1'b1;
        for (int i = 0; i < 300; i++) begin drive0(1'b0, i, 0); tick(); end
        flip = 1'b0; idle(); tick(); tick(); tick();
        chk("perr_sat", 64'(perr_count), PAR ? 64'd255 : 64'd0);

        // Reset one cycle after two reads were accepted
        drive0(1'b0, 1, 0); drive1(1'b0, 2, 0); tick();
        idle(); drive0(1'b0, 3, 0); tick();
        drive0(1'b0, 4, 0); drive1(1'b0, 5, 0); rst = 1'b1; tick();
        rst = 1'b0; tick();
        chk("post_rst_grant", 64'(g_obs), 64'd1);
        idle(); tick(); tick(); tick();
        chk("perr_after_rst", 64'(perr_count), 64'd0);

        // Randomized traffic on a small address window
        pv[0] = 1'b0; pv[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(0, 3) != 0) begin
                    pv[p]  = 1'b1;
                    pwe[p] = 1'($urandom_range(0, 1));
                    pa[p]  = 9'($urandom_range(0, 15));
                    pd[p]  = $urandom;
                end
            end
            req0_valid = pv[0]; req0_we = pwe[0]; req0_addr = pa[0]; req0_wdata = pd[0];
            req1_valid = pv[1]; req1_we = pwe[1]; req1_addr = pa[1]; req1_wdata = pd[1];
            tick();
            if (last_eg == 0) pv[0] = 1'b0;
            else if (last_eg == 1) pv[1] = 1'b0;
        end
        idle(); tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
